// File: rtl/stream_demux_1_2.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_2
// Description : Registered 1-to-2 stream demultiplexer with valid/ready
//               handshake. Whole packets (delimited by in_last) are routed to
//               output 0 or output 1; the route is chosen by in_sel on a
//               packet's first beat and locked until its last beat. Each
//               output keeps a wrapping count of packets fully emitted.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_data/valid/last    - input beat
//               in_sel                - destination, sampled on first beat
//               in_ready              - input beat accepted this cycle
//               outN_data/valid/last  - output N registered beat (N = 0, 1)
//               outN_ready            - output N consumer accepts
//               pkt_cnt0/1            - completed packets per output
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_sel,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    output logic              out0_last,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    output logic              out1_last,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]             r_state;
    logic                   r_route;
    logic [1:0]             r_valid;
    logic [1:0]             r_last;
    logic [1:0][DATA_W-1:0] r_data;
    logic [1:0][CNT_W-1:0]  r_cnt;

    logic       w_esel;
    logic [1:0] w_out_ready;
    logic [1:0] w_out_xfer;
    logic [1:0] w_load;
    logic       w_in_ready;
    logic       w_in_xfer;

    // The route latched at the first beat wins for the rest of the packet,
    // so in_sel toggling mid-packet cannot split it across outputs.
    assign w_esel      = (r_state == ST_IDLE) ? in_sel : r_route;
    assign w_out_ready = {out1_ready, out0_ready};
    assign w_out_xfer  = r_valid & w_out_ready;

    // Only the targeted output register gates acceptance; the other one
    // drains on its own and never stalls this stream.
    assign w_in_ready = ~r_valid[w_esel] | w_out_ready[w_esel];
    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_load     = {w_in_xfer & w_esel, w_in_xfer & ~w_esel};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_route <= 1'b0;
        end else if (w_in_xfer) begin
            if (in_last) begin
                r_state <= ST_IDLE;
            end else if (r_state == ST_IDLE) begin
                r_state <= ST_BUSY;
                r_route <= in_sel;
            end
        end
    end

    // A load takes priority over a drain, so a beat leaving and a new beat
    // arriving in the same cycle keeps valid high with the new payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_last  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_load[n]) begin
                    r_valid[n] <= 1'b1;
                    r_data[n]  <= in_data;
                    r_last[n]  <= in_last;
                end else if (w_out_xfer[n]) begin
                    r_valid[n] <= 1'b0;
                end
                if (w_out_xfer[n] && r_last[n]) begin
                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out0_data  = r_data[0];
    assign out0_valid = r_valid[0];
    assign out0_last  = r_last[0];
    assign out1_data  = r_data[1];
    assign out1_valid = r_valid[1];
    assign out1_last  = r_last[1];
    assign pkt_cnt0   = r_cnt[0];
    assign pkt_cnt1   = r_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1_2
// Description : Self-checking bench for stream_demux_1_2. A queue-based
//               reference model predicts every output and in_ready each
//               cycle; directed packet scenarios are followed by random
//               traffic with random backpressure and occasional resets.
//               A second instance with default widths checks 8-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_2;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid, in_last, in_sel;
    logic              out0_ready, out1_ready;

    logic              in_ready;
    logic [DATA_W-1:0] out0_data, out1_data;
    logic              out0_valid, out0_last, out1_valid, out1_last;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

    logic              w8_in_ready;
    logic [7:0]        w8_out0_data, w8_out1_data;
    logic              w8_out0_valid, w8_out0_last, w8_out1_valid, w8_out1_last;
    logic [7:0]        w8_cnt0, w8_cnt1;

    always #5 clk = ~clk;

    stream_demux_1_2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_sel(in_sel), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid),
        .out0_last(out0_last), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid),
        .out1_last(out1_last), .out1_ready(out1_ready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    stream_demux_1_2 u_dut8 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_sel(in_sel), .in_ready(w8_in_ready),
        .out0_data(w8_out0_data), .out0_valid(w8_out0_valid),
        .out0_last(w8_out0_last), .out0_ready(out0_ready),
        .out1_data(w8_out1_data), .out1_valid(w8_out1_valid),
        .out1_last(w8_out1_last), .out1_ready(out1_ready),
        .pkt_cnt0(w8_cnt0), .pkt_cnt1(w8_cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: one queue of pending {last,data} beats per output,
    // a packet-in-progress flag with its destination, and plain counters.
    logic [DATA_W:0] q0[$];
    logic [DATA_W:0] q1[$];
    bit  m_busy  = 1'b0;
    bit  m_route = 1'b0;
    int  m_cnt0  = 0, m_cnt1 = 0, m_big0 = 0, m_big1 = 0;
    bit  m_fresh = 1'b1;
    bit  chk_en  = 1'b0;

    always @(negedge clk) begin
        bit esel, exp_rdy, x0, x1;
        if (chk_en) begin
            if (m_fresh) begin
                chk("rst_data0", 32'(out0_data), 32'd0);
                chk("rst_data1", 32'(out1_data), 32'd0);
                chk("rst_last0", 32'(out0_last), 32'd0);
                chk("rst_last1", 32'(out1_last), 32'd0);
            end
            chk("valid0", 32'(out0_valid), 32'(q0.size() != 0));
            chk("valid1", 32'(out1_valid), 32'(q1.size() != 0));
            chk("valid0_w8", 32'(w8_out0_valid), 32'(q0.size() != 0));
            chk("valid1_w8", 32'(w8_out1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) begin
                chk("data0", 32'(out0_data), 32'(q0[0][DATA_W-1:0]));
                chk("last0", 32'(out0_last), 32'(q0[0][DATA_W]));
            end
            if (q1.size() != 0) begin
                chk("data1", 32'(out1_data), 32'(q1[0][DATA_W-1:0]));
                chk("last1", 32'(out1_last), 32'(q1[0][DATA_W]));
            end
            chk("cnt0", 32'(pkt_cnt0), 32'(m_cnt0));
            chk("cnt1", 32'(pkt_cnt1), 32'(m_cnt1));
            chk("cnt0_w8", 32'(w8_cnt0), 32'(m_big0));
            chk("cnt1_w8", 32'(w8_cnt1), 32'(m_big1));

            esel    = m_busy ? m_route : in_sel;
            exp_rdy = esel ? (q1.size() == 0 || out1_ready)
                           : (q0.size() == 0 || out0_ready);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("in_ready_w8", 32'(w8_in_ready), 32'(exp_rdy));

            // Advance the model to what the next rising edge should produce.
            if (rst) begin
                q0.delete();
                q1.delete();
                m_busy  = 1'b0;
                m_route = 1'b0;
                m_cnt0  = 0; m_cnt1 = 0; m_big0 = 0; m_big1 = 0;
                m_fresh = 1'b1;
            end else begin
                m_fresh = 1'b0;
                x0 = (q0.size() != 0) && out0_ready;
                x1 = (q1.size() != 0) && out1_ready;
                if (x0) begin
                    if (q0[0][DATA_W]) begin
                        m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
                        m_big0 = (m_big0 + 1) % 256;
                    end
                    void'(q0.pop_front());
                end
                if (x1) begin
                    if (q1[0][DATA_W]) begin
                        m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
                        m_big1 = (m_big1 + 1) % 256;
                    end
                    void'(q1.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    if (esel) q1.push_back({in_last, in_data});
                    else      q0.push_back({in_last, in_data});
                    if (in_last) begin
                        m_busy = 1'b0;
                    end else if (!m_busy) begin
                        m_busy  = 1'b1;
                        m_route = in_sel;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit l,
                       input bit s, input bit r0, input bit r1);
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        in_sel     = s;
        out0_ready = r0;
        out1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);

        // 3-beat packet to output 1
        cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);

        // in_sel toggles mid-packet; must stay on output 0
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Backpressure on output 0
        cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Back-to-back single-beat packets alternating destination
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 8'(8'h70 + i), 1'b1, 1'(i % 2), 1'b1, 1'b1);
        idle(3);

        // Reset in the middle of a 4-beat packet
        cyc(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h82, 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        cyc(1'b1, 8'h91, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Counter wrap with a 2-bit counter: 5 packets end at 1
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);
        chk("wrap_cnt1", 32'(pkt_cnt1), 32'd1);
        chk("wrap_cnt1_w8", 32'(w8_cnt1), 32'd5);

        // Random traffic, random backpressure, occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
                1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end
        rst = 1'b0;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
